// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared across the RV32I core.
//   - Major opcode constants (instr[6:0])
//   - NOP_INSTR: canonical ADDI x0, x0, 0
//   - PC_SRC_* : next-PC select encodings driven by the control stage
//   - fetch_state_t: fetch-stage FSM state encoding
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HOLD  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC selection for the fetch stage.
// Ports:
//   pc            in   current fetch PC
//   pc_src        in   select: seq / branch / jalr (reserved code behaves as seq)
//   branch_target in   PC+imm from datapath
//   jalr_target   in   ALU result for jalr (bit0 cleared here)
//   next_pc       out  selected PC with bits [1:0] forced to zero
//   misaligned    out  selected PC had nonzero bits [1:0] before forcing
module pc_next_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] sel_pc;

    always_comb begin
        sel_pc = pc + XLEN'(4);
        case (pc_src)
            PC_SRC_BRANCH: sel_pc = branch_target;
            PC_SRC_JALR:   sel_pc = {jalr_target[XLEN-1:1], 1'b0};
            default:       sel_pc = pc + XLEN'(4);
        endcase
    end

    // Fetch addresses are always word-aligned; a bad target is flagged and
    // rounded down rather than fetched as-is.
    assign misaligned = |sel_pc[1:0];
    assign next_pc    = {sel_pc[XLEN-1:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage. Owns the PC, issues one word request
// at a time to instruction memory and holds the fetched instruction stable
// for decode until instr_ready, then applies the next-PC selection.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   imem_req, imem_addr            request to instruction memory
//   imem_gnt                       memory accepted the request
//   imem_rvalid, imem_rdata        read response
//   instr_valid, instr,
//   instr_pc, instr_pc_plus4       held instruction and its PCs
//   instr_ready                    decode done with current instruction
//   pc_src, branch_target,
//   jalr_target                    next-PC selection inputs (sampled with instr_ready)
//   pc_misaligned                  one-cycle pulse after a misaligned target
// Only XLEN = 32 is supported.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            instr_ready,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            pc_misaligned
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            latch_instr;
    logic            advance_pc;

    pc_next_mux #(
        .XLEN (XLEN)
    ) u_pc_next_mux (
        .pc            (pc),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .next_pc       (next_pc),
        .misaligned    (next_misaligned)
    );

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        latch_instr = 1'b0;
        advance_pc  = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    latch_instr = 1'b1;
                    state_next  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    advance_pc = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            instr         <= NOP_INSTR;
            instr_pc      <= RESET_PC;
            pc_misaligned <= 1'b0;
        end else begin
            state         <= state_next;
            pc_misaligned <= 1'b0;
            if (latch_instr) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (advance_pc) begin
                pc            <= next_pc;
                pc_misaligned <= next_misaligned;
            end
        end
    end

    // pc only changes on leaving HOLD, so the address is naturally stable
    // for the whole request phase.
    assign imem_addr      = pc;
    assign instr_pc_plus4 = instr_pc + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        pc_misaligned;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_ready    (instr_ready),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .jalr_target    (jalr_target),
        .pc_misaligned  (pc_misaligned)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [95:0] exp_q[$];
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory contents: a fixed scramble of the address; word 0 holds 0x33.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    // Next PC from the architectural rules: {misaligned, aligned next pc}.
    function automatic logic [32:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                               input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] t;
        if (src == 2'd1)      t = bt;
        else if (src == 2'd2) t = jt & 32'hFFFF_FFFE;
        else                  t = pc + 32'd4;
        return {(t % 4) != 0, t - (t % 4)};
    endfunction

    // Monitor: pops an expected instruction whenever a new one is presented,
    // and checks it stays frozen while valid.
    logic        prev_v   = 1'b0;
    logic        prev_mis = 1'b0;
    logic [95:0] cur;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_v   = 1'b0;
            prev_mis = 1'b0;
        end else begin
            if (instr_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("instr", instr, cur[95:64]);
                    check("instr_pc", instr_pc, cur[63:32]);
                    check("instr_pc_plus4", instr_pc_plus4, cur[31:0]);
                end
            end else if (instr_valid) begin
                check("instr_frozen", instr, cur[95:64]);
                check("instr_pc_frozen", instr_pc, cur[63:32]);
            end
            if (prev_mis) check("mis_one_cycle", {31'd0, pc_misaligned}, 32'd0);
            prev_v   = instr_valid;
            prev_mis = pc_misaligned;
        end
    end

    task automatic check_reset_vals();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, RESET_PC);
        check("rst_pc_plus4", instr_pc_plus4, RESET_PC + 32'd4);
        check("rst_mis", {31'd0, pc_misaligned}, 32'd0);
    endtask

    // Waits (bounded) for a request at the current negedge or later.
    task automatic wait_req(output bit ok);
        for (int i = 0; i < 64 && imem_req !== 1'b1; i++) @(negedge clk);
        ok = (imem_req === 1'b1);
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    // One full fetch transaction with given memory/downstream delays,
    // finishing with the next-PC handshake.
    task automatic fetch(input int gnt_d, input int rv_d, input int rdy_d,
                         input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt,
                         output int unsigned t_req);
        bit ok;
        logic [32:0] nxt;
        wait_req(ok);
        t_req = cyc;
        if (!ok) return;
        check("req_addr", imem_addr, model_pc);
        for (int i = 0; i < gnt_d; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            pc_src      = 2'($urandom_range(0, 3));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clk);
            check("req_hold", {31'd0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, model_pc);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        imem_gnt    = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check("req_drop", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rv_d; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            pc_src      = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("early_valid", {31'd0, instr_valid}, 32'd0);
        end
        instr_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(model_pc);
        exp_q.push_back({mem_word(model_pc), model_pc, model_pc + 32'd4});
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        for (int i = 0; i < rdy_d; i++) @(negedge clk);
        pc_src        = src;
        branch_target = bt;
        jalr_target   = jt;
        instr_ready   = 1'b1;
        nxt = model_next(model_pc, src, bt, jt);
        @(negedge clk);
        instr_ready = 1'b0;
        check("misaligned", {31'd0, pc_misaligned}, {31'd0, nxt[32]});
        check("valid_fall", {31'd0, instr_valid}, 32'd0);
        model_pc = nxt[31:0];
    endtask

    int unsigned t0, t1;
    bit ok;

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; pc_src = 2'd0; branch_target = '0; jalr_target = '0;
        model_pc = RESET_PC;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        check("idle_no_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("fetch_req", {31'd0, imem_req}, 32'd1);

        // Zero-wait sequential throughput
        fetch(0, 0, 0, 2'd0, 32'h0, 32'h0, t0);
        fetch(0, 0, 0, 2'd0, 32'h0, 32'h0, t1);
        check("rate_1", t1 - t0, 32'd3);
        t0 = t1;
        fetch(0, 0, 0, 2'd0, 32'h0, 32'h0, t1);
        check("rate_2", t1 - t0, 32'd3);
        // Branch, misaligned jalr, slow memory, wrap
        fetch(0, 0, 0, 2'd1, 32'h0000_0040, 32'h0, t1);
        fetch(1, 1, 1, 2'd2, 32'h0, 32'h0000_0103, t1);
        check("jalr_addr", model_pc, 32'h0000_0100);
        fetch(4, 3, 2, 2'd1, 32'hFFFF_FFFC, 32'h0, t1);
        fetch(0, 2, 0, 2'd0, 32'h0, 32'h0, t1);
        fetch(2, 0, 0, 2'd3, 32'h0000_0020, 32'h0, t1);
        fetch(0, 0, 0, 2'd1, 32'h0000_0020, 32'h0, t1);

        // Reset while waiting for the response at pc 0x20
        wait_req(ok);
        check("pre_rst_addr", imem_addr, 32'h0000_0020);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        model_pc = RESET_PC;
        @(negedge clk);
        fetch(0, 0, 0, 2'd0, 32'h0, 32'h0, t1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            fetch($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 2),
                  2'($urandom_range(0, 3)), $urandom, $urandom, t1);
        end

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
